// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - slow-clock high/low/period meter in clk_in cycles
//
// Purpose:
//   Measures a slow clock (divided clock or external oscillator) against the
//   system clock clk_in. Reports the length of the last complete high level,
//   the last complete low level and their sum. It also provides a lock flag
//   and a stall timeout pulse.
//
// Ports:
//   clk_in      in   1       system clock, rising edge
//   reset_n     in   1       asynchronous active-low reset
//   enable      in   1       measurement enable; low forces IDLE and clears results
//   clk_meas    in   1       clock under measurement, asynchronous to clk_in
//   high_len    out  SIZE    clk_in cycles of last complete high level
//   low_len     out  SIZE    clk_in cycles of last complete low level
//   period      out  SIZE+1  high_len + low_len, updated with meas_valid
//   meas_valid  out  1       one-cycle pulse: new period available
//   locked      out  1       at least one full period measured since acquire
//   timeout     out  1       one-cycle pulse: no edge for 2^SIZE-1 cycles

module clock_period_meter #(
  parameter int SIZE        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            clk_meas,
  output logic [SIZE-1:0] high_len,
  output logic [SIZE-1:0] low_len,
  output logic [SIZE:0]   period,
  output logic            meas_valid,
  output logic            locked,
  output logic            timeout
);

  localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] CNT_MAX = {SIZE{1'b1}};
  // Count value one cycle before saturation; used to fire timeout exactly once.
  localparam logic [SIZE-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SIZE-1:0]        cnt_q;
  logic                   have_high;

  logic                   sync_last;
  logic                   edge_det;
  logic                   rise;
  logic                   fall;
  logic                   cnt_sat;
  logic [SIZE-1:0]        cnt_inc;
  logic [SIZE:0]          period_sum;

  // The synchronizer and the previous-level flop run regardless of enable.
  // This prevents a stale level from showing up as a false edge on re-enable.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_meas};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_det  = sync_last ^ prev_q;
  assign rise      = edge_det & sync_last;
  assign fall      = edge_det & ~sync_last;

  // cnt holds (level length - 1) on the edge cycle.
  // The latched length is therefore cnt+1, saturating at all-ones.
  assign cnt_sat    = (cnt_q == CNT_MAX);
  assign cnt_inc    = cnt_sat ? CNT_MAX : (cnt_q + CNT_ONE);
  assign period_sum = {1'b0, high_len} + {1'b0, cnt_inc};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt_q      <= '0;
      have_high  <= 1'b0;
      high_len   <= '0;
      low_len    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt_q     <= '0;
        have_high <= 1'b0;
        locked    <= 1'b0;
        high_len  <= '0;
        low_len   <= '0;
        period    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQUIRE;
            cnt_q <= '0;
          end
          ACQUIRE, MEASURE: begin
            if (edge_det) begin
              // An edge always wins over saturation: a saturated length is
              // latched and no timeout is raised in this cycle.
              cnt_q <= '0;
              if (state == ACQUIRE) begin
                // The level that just ended started before we were looking.
                state <= MEASURE;
              end else if (fall) begin
                high_len  <= cnt_inc;
                have_high <= 1'b1;
              end else if (rise) begin
                low_len <= cnt_inc;
                if (have_high) begin
                  period     <= period_sum;
                  meas_valid <= 1'b1;
                  locked     <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_inc;
              // Fire only on the step into saturation.
              // A held, saturated count stays silent until the next edge.
              if (cnt_q == CNT_PRE) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                have_high <= 1'b0;
                state     <= ACQUIRE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed self-checking bench for clock_period_meter
module tb_clock_period_meter;

  localparam int SIZE = 8;

  logic            clk_in;
  logic            reset_n;
  logic            enable;
  logic            clk_meas;
  logic [SIZE-1:0] high_len;
  logic [SIZE-1:0] low_len;
  logic [SIZE:0]   period;
  logic            meas_valid;
  logic            locked;
  logic            timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_timeout = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_to_cyc = 0;
  int snap_v;
  int snap_t;

  clock_period_meter #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .clk_meas   (clk_meas),
    .high_len   (high_len),
    .low_len    (low_len),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (meas_valid) begin
      n_valid = n_valid + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (timeout) begin
      n_timeout = n_timeout + 1;
      last_to_cyc = cyc;
    end
    if (meas_valid && timeout) n_both = n_both + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clk_in cycles.
  // Control returns 2ns after a rising edge, so inputs never change at an edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  // n periods of hi cycles high followed by lo cycles low.
  task automatic gen(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      clk_meas = 1'b1;
      step(hi);
      clk_meas = 1'b0;
      step(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_high"},  high_len,   0);
    check_val({tag, "_low"},   low_len,    0);
    check_val({tag, "_per"},   period,     0);
    check_val({tag, "_lock"},  locked,     0);
    check_val({tag, "_valid"}, meas_valid, 0);
    check_val({tag, "_to"},    timeout,    0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad = n_bad + 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    clk_meas = 1'b0;
    step(3);
    check_zero("rst");

    // Divide by 2: one-cycle levels.
    reset_n = 1'b1;
    step(2);
    enable = 1'b1;
    step(2);
    check_val("acq_lock", locked, 0);
    gen(1, 1, 20);
    clk_meas = 1'b1;
    step(4);
    check_val("d1_high", high_len, 1);
    check_val("d1_low",  low_len,  1);
    check_val("d1_per",  period,   2);
    check_val("d1_lock", locked,   1);
    check_val("d1_nval", n_valid,  20);
    check_val("d1_gap",  last_valid_cyc - prev_valid_cyc, 2);

    // Four cycles high and four cycles low.
    gen(4, 4, 6);
    check_val("d4_high", high_len, 4);
    check_val("d4_low",  low_len,  4);
    check_val("d4_per",  period,   8);
    check_val("d4_gap",  last_valid_cyc - prev_valid_cyc, 8);

    // Duty cycle of 3 high and 5 low.
    gen(3, 5, 4);
    check_val("duty_high", high_len, 3);
    check_val("duty_low",  low_len,  5);
    check_val("duty_per",  period,   8);

    // A 255-cycle level ends exactly at saturation: the length is latched
    // and no timeout is raised.
    snap_t = n_timeout;
    gen(255, 5, 2);
    check_val("sat_high", high_len, 255);
    check_val("sat_low",  low_len,  5);
    check_val("sat_per",  period,   260);
    check_val("sat_noto", n_timeout - snap_t, 0);

    // Stuck high after lock: expect one timeout 255 cycles after the last edge.
    clk_meas = 1'b1;
    step(300);
    check_val("stk_nto",  n_timeout - snap_t, 1);
    check_val("stk_dly",  last_to_cyc - last_valid_cyc, 255);
    check_val("stk_lock", locked, 0);
    step(300);
    check_val("stk_once", n_timeout - snap_t, 1);
    check_val("stk_high", high_len, 255);
    check_val("stk_per",  period,   260);

    // Resume with divide by 4 (two-cycle levels): the first period is discarded.
    snap_v = n_valid;
    gen(2, 2, 5);
    clk_meas = 1'b1;
    step(4);
    check_val("res_nval", n_valid - snap_v, 4);
    check_val("res_per",  period, 4);
    check_val("res_lock", locked, 1);

    // Drop enable mid-level for about 10 cycles.
    gen(4, 4, 3);
    clk_meas = 1'b1;
    step(3);
    enable = 1'b0;
    step(1);
    snap_v = n_valid;
    snap_t = n_timeout;
    check_zero("dis");
    step(1);
    clk_meas = 1'b0;
    step(4);
    clk_meas = 1'b1;
    step(4);
    check_val("dis_nval", n_valid - snap_v, 0);
    check_val("dis_nto",  n_timeout - snap_t, 0);
    check_val("dis_per",  period, 0);
    enable = 1'b1;
    gen(4, 4, 6);
    clk_meas = 1'b1;
    step(4);
    check_val("ren_nval", n_valid - snap_v, 5);
    check_val("ren_per",  period, 8);
    check_val("ren_high", high_len, 4);
    check_val("ren_lock", locked, 1);
    check_val("ren_nto",  n_timeout - snap_t, 0);

    // Asynchronous reset between clock edges, mid-level.
    step(2);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("arst");
    clk_meas = 1'b0;
    step(3);
    reset_n = 1'b1;
    snap_v = n_valid;
    step(3);
    gen(4, 4, 1);
    check_val("arst_nval0", n_valid - snap_v, 0);
    check_val("arst_lock0", locked, 0);
    gen(4, 4, 1);
    clk_meas = 1'b1;
    step(4);
    check_val("arst_nval", n_valid - snap_v, 2);
    check_val("arst_per",  period, 8);
    check_val("arst_lock", locked, 1);

    check_val("excl",     n_both, 0);
    check_val("to_total", n_timeout, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
